satagtx_rst_seq: RTL and testbench

SATAGTX_RST_SEQ -- requirements
Module: satagtx_rst_seq

---
 rtl/satagtx_rst_seq.sv | 129 ++++++++++++
 tb/tb_satagtx_rst_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/satagtx_rst_seq.sv
// GTX tile reset sequencer: GTXRESET pulse, PLL/DCM lock waits, PCS reset release and
// lock supervision with timeout-driven restarts. Single fabric clock, synchronous reset.
module satagtx_rst_seq #(
  parameter string       C_FAMILY          = "none",
  parameter int unsigned C_GTXRESET_CYCLES = 16,
  parameter int unsigned C_USR_RST_CYCLES  = 8,
  parameter int unsigned C_LOCK_TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tile0_plllkdet,
  input  logic       refclkout_dcm0_locked,
  input  logic       tile0_txresetdone,
  input  logic       tile0_rxresetdone,
  output logic       tile0_gtxreset,
  output logic       tile0_txreset,
  output logic       tile0_rxreset,
  output logic       link_ready,
  output logic [3:0] retry_cnt
);

  localparam logic [15:0] GtxLast     = 16'(C_GTXRESET_CYCLES - 1);
  localparam logic [15:0] UsrLast     = 16'(C_USR_RST_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(C_LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StGtxRst,
    StWaitPll,
    StWaitDcm,
    StUsrRst,
    StWaitDone,
    StReady
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  retry_q;
  logic        retry_inc;
  logic        gtx_q, tx_q, rx_q, ready_q;
  logic        pll_s, dcm_s, txdone_s, rxdone_s;
  logic        timeout;

  assign {rxdone_s, txdone_s, dcm_s, pll_s} = sync2_q;
  assign timeout = (cnt_q == TimeoutLast);

  // Loss checks come first in every locked state so PLL loss beats DCM loss beats the rest.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    unique case (state_q)
      StGtxRst: begin
        if (cnt_q == GtxLast) state_d = StWaitPll;
      end
      StWaitPll: begin
        if (pll_s) begin
          state_d = StWaitDcm;
        end else if (timeout) begin
          state_d   = StGtxRst;
          retry_inc = 1'b1;
        end
      end
      StWaitDcm: begin
        if (!pll_s) begin
          state_d = StGtxRst;
        end else if (dcm_s) begin
          state_d = StUsrRst;
        end else if (timeout) begin
          state_d   = StGtxRst;
          retry_inc = 1'b1;
        end
      end
      StUsrRst: begin
        if (!pll_s)                state_d = StGtxRst;
        else if (!dcm_s)           state_d = StWaitDcm;
        else if (cnt_q == UsrLast) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!pll_s) begin
          state_d = StGtxRst;
        end else if (!dcm_s) begin
          state_d = StWaitDcm;
        end else if (txdone_s && rxdone_s) begin
          state_d = StReady;
        end else if (timeout) begin
          state_d   = StGtxRst;
          retry_inc = 1'b1;
        end
      end
      StReady: begin
        if (!pll_s)      state_d = StGtxRst;
        else if (!dcm_s) state_d = StWaitDcm;
      end
      default: state_d = StGtxRst;
    endcase
  end

  // Outputs are decoded from state_d so they change on the edge that enters the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StGtxRst;
      cnt_q   <= 16'd0;
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      retry_q <= 4'd0;
      gtx_q   <= 1'b1;
      tx_q    <= 1'b1;
      rx_q    <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= {tile0_rxresetdone, tile0_txresetdone, refclkout_dcm0_locked, tile0_plllkdet};
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      if (retry_inc && (retry_q != 4'hF)) retry_q <= retry_q + 4'd1;
      gtx_q   <= (state_d == StGtxRst);
      tx_q    <= !(state_d inside {StWaitDone, StReady});
      rx_q    <= !(state_d inside {StWaitDone, StReady});
      ready_q <= (state_d == StReady);
    end
  end

  assign tile0_gtxreset = gtx_q;
  assign tile0_txreset  = tx_q;
  assign tile0_rxreset  = rx_q;
  assign link_ready     = ready_q;
  assign retry_cnt      = retry_q;

endmodule

// File: tb/tb_satagtx_rst_seq.sv
// Directed bench for satagtx_rst_seq: expected output vectors are queued as stimulus is
// applied and compared at the negedge where the DUT is due to present them.
module tb_satagtx_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll, dcm, txdone, rxdone;
  logic       gtxreset, txreset, rxreset, link_ready;
  logic [3:0] retry_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];

  bit mon_en     = 1'b0;
  bit seen_ready = 1'b0;

  satagtx_rst_seq #(
    .C_FAMILY          ("virtex5"),
    .C_GTXRESET_CYCLES (16),
    .C_USR_RST_CYCLES  (8),
    .C_LOCK_TIMEOUT    (100)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .tile0_plllkdet        (pll),
    .refclkout_dcm0_locked (dcm),
    .tile0_txresetdone     (txdone),
    .tile0_rxresetdone     (rxdone),
    .tile0_gtxreset        (gtxreset),
    .tile0_txreset         (txreset),
    .tile0_rxreset         (rxreset),
    .link_ready            (link_ready),
    .retry_cnt             (retry_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && link_ready) seen_ready = 1'b1;

  function automatic logic [7:0] pk(input logic g, input logic t, input logic r,
                                    input logic l, input logic [3:0] rc);
    return {g, t, r, l, rc};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_front();
    exp_t       e;
    logic [7:0] obs;
    e   = sb_q.pop_front();
    obs = {gtxreset, txreset, rxreset, link_ready, retry_cnt};
    n_assert++;
    assert (obs === e.val)
    else begin
      n_fail++;
      $error("FAIL %s: observed gtx/tx/rx/rdy/retry=%b required %b", e.tag, obs, e.val);
    end
  endtask

  task automatic expect_after(input int n, input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
    step(n);
    check_front();
  endtask

  // sel_ready=1 waits on link_ready, else on txreset.
  task automatic wait_for(input bit sel_ready, input logic val, input int budget,
                          input string tag);
    int i;
    i = 0;
    while (((sel_ready ? link_ready : txreset) !== val) && (i < budget)) begin
      step(1);
      i++;
    end
    n_assert++;
    assert (i < budget)
    else begin
      n_fail++;
      $error("FAIL %s: signal still %b after %0d cycles, required %b", tag,
             sel_ready ? link_ready : txreset, budget, val);
    end
  endtask

  initial begin
    rst_n = 1'b0; pll = 1'b0; dcm = 1'b0; txdone = 1'b0; rxdone = 1'b0;
    expect_after(2, "reset_state", pk(1, 1, 1, 0, 4'd0));
    pll = 1'b1; dcm = 1'b1; txdone = 1'b1; rxdone = 1'b1;
    expect_after(4, "reset_hold", pk(1, 1, 1, 0, 4'd0));

    // Nominal bring-up
    pll = 1'b0; dcm = 1'b0; txdone = 1'b0; rxdone = 1'b0;
    rst_n = 1'b1;
    expect_after(15, "gtx_pulse_end", pk(1, 1, 1, 0, 4'd0));
    expect_after(1, "wait_pll", pk(0, 1, 1, 0, 4'd0));
    step(24);
    pll = 1'b1;
    step(60);
    dcm = 1'b1;
    expect_after(10, "usr_rst_hold", pk(0, 1, 1, 0, 4'd0));
    expect_after(1, "usr_rst_release", pk(0, 0, 0, 0, 4'd0));
    step(30);
    txdone = 1'b1; rxdone = 1'b1;
    expect_after(2, "done_sync", pk(0, 0, 0, 0, 4'd0));
    expect_after(1, "ready_nominal", pk(0, 0, 0, 1, 4'd0));

    // DCM drop in READY for 5 cycles
    dcm = 1'b0;
    expect_after(2, "dcm_drop_sync", pk(0, 0, 0, 1, 4'd0));
    expect_after(1, "dcm_drop_wait", pk(0, 1, 1, 0, 4'd0));
    step(2);
    dcm = 1'b1;
    wait_for(1'b1, 1'b1, 40, "dcm_relock_ready");
    expect_after(0, "dcm_relock_state", pk(0, 0, 0, 1, 4'd0));

    // Partial done: only TX done, three timeouts in WAIT_DONE
    rxdone = 1'b0;
    dcm    = 1'b0;
    expect_after(3, "to_wait_dcm", pk(0, 1, 1, 0, 4'd0));
    dcm = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_for(1'b0, 1'b0, 60, "reach_wait_done");
      expect_after(0, "wait_done", pk(0, 0, 0, 0, 4'(r)));
      expect_after(99, "partial_pre_to", pk(0, 0, 0, 0, 4'(r)));
      expect_after(1, "partial_timeout", pk(1, 1, 1, 0, 4'(r + 1)));
    end
    wait_for(1'b0, 1'b0, 60, "reach_wait_done_r3");
    expect_after(0, "wait_done_r3", pk(0, 0, 0, 0, 4'd3));

    // One-cycle reset mid-operation
    rst_n = 1'b0;
    expect_after(1, "mid_reset", pk(1, 1, 1, 0, 4'd0));
    rst_n = 1'b1;
    expect_after(15, "mid_gtx_pulse_end", pk(1, 1, 1, 0, 4'd0));
    expect_after(1, "mid_wait_pll", pk(0, 1, 1, 0, 4'd0));
    rxdone = 1'b1;
    wait_for(1'b1, 1'b1, 60, "mid_reach_ready");
    expect_after(0, "mid_ready", pk(0, 0, 0, 1, 4'd0));

    // Simultaneous PLL and DCM loss in READY
    pll = 1'b0; dcm = 1'b0;
    expect_after(2, "dual_loss_sync", pk(0, 0, 0, 1, 4'd0));
    expect_after(1, "dual_loss_gtx", pk(1, 1, 1, 0, 4'd0));

    // PLL never locks: retry every 116 cycles, saturating at 15
    mon_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      expect_after(115, "pll_wait", pk(0, 1, 1, 0, 4'((k - 1) > 15 ? 15 : (k - 1))));
      expect_after(1, "pll_timeout", pk(1, 1, 1, 0, 4'(k > 15 ? 15 : k)));
    end
    mon_en = 1'b0;
    n_assert++;
    assert (seen_ready === 1'b0)
    else begin
      n_fail++;
      $error("FAIL pll_timeout_no_ready: observed %b required 0", seen_ready);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
